// File: rtl/rr_fifo_pkg.sv
// Shared constants and the stored-entry layout for the round-robin FIFO arbiter.
package rr_fifo_pkg;
  localparam int RR_NUM_REQ = 4;
  localparam int RR_DATA_W  = 8;
  localparam int RR_SRC_W   = $clog2(RR_NUM_REQ);

  typedef struct packed {
    logic [RR_SRC_W-1:0]  src;
    logic [RR_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/rr_fifo_arbiter_sync_fifo.sv
// Circular FIFO of {src, data} entries with registered pop output.
// Storage, read/write pointers and occupancy live here.
module sync_fifo
  import rr_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  entry_t                       i_push_entry,
  input  logic                         i_pop,
  output logic                         o_pop_valid,
  output entry_t                       o_pop_entry,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_pop_valid;
  entry_t             r_pop_entry;
  logic               w_wr_en;
  logic               w_rd_en;

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == {CNT_W{1'b0}});
  assign o_count     = r_count;
  assign o_pop_valid = r_pop_valid;
  assign o_pop_entry = r_pop_entry;
  assign w_wr_en     = i_push & ~o_full;
  assign w_rd_en     = i_pop & ~o_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_pop_valid <= 1'b0;
      r_pop_entry <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr    <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
        r_pop_valid <= 1'b1;
        r_pop_entry <= r_mem[r_rd_ptr];
      end else begin
        r_pop_valid <= 1'b0;
        r_pop_entry <= '0;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter granting one requester per cycle a push into a shared FIFO.
// The priority pointer moves past each winner; the FIFO is a sync_fifo instance.
module rr_fifo_arbiter
  import rr_fifo_pkg::*;
#(
  parameter int NUM_REQ = RR_NUM_REQ,
  parameter int DATA_W  = RR_DATA_W,
  parameter int DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  input  logic                              pop_i,
  output logic                              pop_valid_o,
  output logic [DATA_W-1:0]                 pop_data_o,
  output logic [$clog2(NUM_REQ)-1:0]        pop_src_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]   r_ptr;
  logic [SRC_W-1:0]   w_win;
  logic [SRC_W-1:0]   w_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_push;
  logic               w_full;
  entry_t             w_push_entry;
  entry_t             w_pop_entry;

  // Search upward from r_ptr with wrap; first active request wins.
  always_comb begin
    w_win   = {SRC_W{1'b0}};
    w_idx   = {SRC_W{1'b0}};
    w_found = 1'b0;
    w_gnt   = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = SRC_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    if (w_found && !w_full && !reset) begin
      w_gnt[w_win] = 1'b1;
    end else begin
      w_gnt = {NUM_REQ{1'b0}};
    end
  end

  assign w_push = |w_gnt;
  assign gnt_o  = w_gnt;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.src  = w_win;
    w_push_entry.data = req_data_i[w_win];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= {SRC_W{1'b0}};
    end else if (w_push) begin
      r_ptr <= (w_win == SRC_W'(NUM_REQ-1)) ? {SRC_W{1'b0}} : w_win + SRC_W'(1);
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (pop_i),
    .o_pop_valid  (pop_valid_o),
    .o_pop_entry  (w_pop_entry),
    .o_full       (w_full),
    .o_empty      (empty_o),
    .o_count      (count_o)
  );

  assign full_o     = w_full;
  assign pop_data_o = w_pop_entry.data;
  assign pop_src_o  = w_pop_entry.src;
endmodule
